// File: rtl/seq_frame_scanner.sv
// rtl/seq_frame_scanner.sv - frame-level serial pattern scanner with match counting
//
// Accepts DATA_W-bit words over a valid/ready handshake and shifts each one
// out MSB-first, one bit per cycle. A Moore-style detector compares a
// PAT_LEN-bit sliding window against the pattern latched at frame start and
// counts hits. The window carries across word boundaries within a frame.
//
// Optional feature macro: SEQ_SCAN_NONOVLP_EN
//   defined   - cfg_overlap selects overlapping (1) or non-overlapping (0)
//   undefined - cfg_overlap is ignored, detection is always overlapping
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   cfg_pattern   pattern, MSB is the first bit in time (latched per frame)
//   cfg_overlap   overlap mode select (latched per frame)
//   in_valid/in_ready/in_data/in_last   word input handshake
//   bit_out/bit_valid                   serial bit currently scanned
//   match         registered pulse, pattern completed on the previous bit
//   match_count   saturating match count of the current/last frame
//   frame_done    one-cycle pulse at the end of a frame
//   busy          frame in progress
module seq_frame_scanner #(
  parameter int DATA_W  = 8,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  output logic               bit_out,
  output logic               bit_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               frame_done,
  output logic               busy
);

  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]  sreg;
  logic [IDX_W-1:0]   bit_idx;
  logic               last_lat;
  logic [PAT_LEN-1:0] pat_lat;
  logic [PAT_LEN-1:0] win;
  logic [PAT_LEN-1:0] win_nxt;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_nxt;
  logic               hit;

`ifdef SEQ_SCAN_NONOVLP_EN
  logic ovl_lat;
`else
  logic unused_cfg_overlap;
  assign unused_cfg_overlap = cfg_overlap;
`endif

  // Next-state and handshake/strobe outputs
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    bit_valid  = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        bit_valid = 1'b1;
        if (bit_idx == '0) state_nxt = last_lat ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bit_out = bit_valid & sreg[DATA_W-1];

  // Window as it will look after absorbing the current bit; a hit needs a
  // full window so that stale or cleared history never produces a match.
  assign win_nxt  = {win[PAT_LEN-2:0], sreg[DATA_W-1]};
  assign fill_nxt = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
  assign hit      = bit_valid && (fill_nxt == FILL_FULL) && (win_nxt == pat_lat);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      sreg        <= '0;
      bit_idx     <= '0;
      last_lat    <= 1'b0;
      pat_lat     <= '0;
      win         <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
      busy        <= 1'b0;
`ifdef SEQ_SCAN_NONOVLP_EN
      ovl_lat     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      match <= hit;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sreg     <= in_data;
            bit_idx  <= IDX_LAST;
            last_lat <= in_last;
            // First word of a frame: snapshot config and restart detection
            if (!busy) begin
              pat_lat     <= cfg_pattern;
              win         <= '0;
              fill        <= '0;
              match_count <= '0;
              busy        <= 1'b1;
`ifdef SEQ_SCAN_NONOVLP_EN
              ovl_lat     <= cfg_overlap;
`endif
            end
          end
        end
        S_SHIFT: begin
          sreg    <= sreg << 1;
          bit_idx <= bit_idx - 1'b1;
          win     <= win_nxt;
`ifdef SEQ_SCAN_NONOVLP_EN
          // Non-overlapping: a hit consumes the window, so refill from empty
          fill    <= (hit && !ovl_lat) ? '0 : fill_nxt;
`else
          fill    <= fill_nxt;
`endif
          if (hit && (match_count != '1)) match_count <= match_count + 1'b1;
          if ((bit_idx == '0) && last_lat) busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
